// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared 8-bit ALU. The winning request is
// executed in one cycle and held in a result register until the consumer takes it.
module alu_arbiter #(
    parameter int WIDTH = 8,
    parameter bit FAIR  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_tag,
    output logic             res_zero,
    input  logic             res_ready
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t               state;
    logic                 last_grant;
    logic                 both_valid;
    logic                 any_valid;
    logic                 can_accept;
    logic                 grant;
    logic                 pick1;
    logic [2:0]           alu_op;
    logic [WIDTH-1:0]     alu_a;
    logic [WIDTH-1:0]     alu_b;
    logic [WIDTH-1:0]     alu_out;
    logic [2*WIDTH-1:0]   product;

    assign both_valid = req0_valid && req1_valid;
    assign any_valid  = req0_valid || req1_valid;
    assign can_accept = (state == EMPTY) || res_ready;
    // Gating with rst_n keeps a reset edge from ever looking like an accepted handshake.
    assign grant      = rst_n && can_accept && any_valid;
    assign pick1      = both_valid ? (FAIR ? ~last_grant : 1'b0) : req1_valid;

    assign req0_ready = grant && !pick1;
    assign req1_ready = grant && pick1;

    assign alu_op  = pick1 ? req1_op : req0_op;
    assign alu_a   = pick1 ? req1_a  : req0_a;
    assign alu_b   = pick1 ? req1_b  : req0_b;
    assign product = {{WIDTH{1'b0}}, alu_a} * {{WIDTH{1'b0}}, alu_b};

    always_comb begin
        alu_out = '0;
        case (alu_op)
            3'b000:  alu_out = ~alu_a;
            3'b001:  alu_out = alu_a | alu_b;
            3'b010:  alu_out = alu_a ^ alu_b;
            3'b011:  alu_out = alu_a & alu_b;
            3'b100:  alu_out = product[WIDTH-1:0];
            3'b101:  alu_out = alu_a + alu_b;
            3'b110:  alu_out = alu_a - alu_b;
            default: alu_out = '0;
        endcase
    end

    assign res_valid = (state == FULL);

    // last_grant resets to 1 so that requester 0 wins the first contested round.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            res_data   <= '0;
            res_tag    <= 1'b0;
            res_zero   <= 1'b0;
            last_grant <= 1'b1;
        end else if (grant) begin
            state      <= FULL;
            res_data   <= alu_out;
            res_tag    <= pick1;
            res_zero   <= (alu_out == '0);
            last_grant <= pick1;
        end else if ((state == FULL) && res_ready) begin
            state <= EMPTY;
        end
    end

endmodule
